// File: rtl/instr_trace_buf_pkg.sv
// Shared MIPS encodings (opcode, funct, REGIMM rt, COP0 rs) and trace capture state.
// Pure definitions: no logic, no latency, no flow control.
package instr_trace_buf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI     = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                         OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03,
                         FN_SLLV  = 6'h04, FN_SRLV  = 6'h06, FN_SRAV  = 6'h07,
                         FN_JR    = 6'h08, FN_JALR  = 6'h09, FN_SYSC  = 6'h0C,
                         FN_BREAK = 6'h0D, FN_MFHI  = 6'h10, FN_MTHI  = 6'h11,
                         FN_MFLO  = 6'h12, FN_MTLO  = 6'h13, FN_MULT  = 6'h18,
                         FN_MULTU = 6'h19, FN_DIV   = 6'h1A, FN_DIVU  = 6'h1B,
                         FN_ADD   = 6'h20, FN_ADDU  = 6'h21, FN_SUB   = 6'h22,
                         FN_SUBU  = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
                         FN_XOR   = 6'h26, FN_NOR   = 6'h27, FN_SLT   = 6'h2A,
                         FN_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_ERET = 5'h10;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

endpackage

// File: rtl/instr_trace_buf_mnem_decode.sv
// Combinational MIPS instruction -> right-aligned 5-character ASCII mnemonic.
// Zero latency, no flow control.
module mnem_decode
  import instr_trace_buf_pkg::*;
(
  input  logic [31:0] instr,
  output logic [39:0] ascii
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];

  always_comb begin
    ascii = {16'h0, "N-R"};
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:   ascii = {16'h0, "AND"};
          FN_OR:    ascii = {24'h0, "OR"};
          FN_XOR:   ascii = {16'h0, "XOR"};
          FN_NOR:   ascii = {16'h0, "NOR"};
          FN_SLL:   ascii = {16'h0, "SLL"};
          FN_SRL:   ascii = {16'h0, "SRL"};
          FN_SRA:   ascii = {16'h0, "SRA"};
          FN_SLLV:  ascii = {8'h0, "SLLV"};
          FN_SRLV:  ascii = {8'h0, "SRLV"};
          FN_SRAV:  ascii = {8'h0, "SRAV"};
          FN_MFHI:  ascii = {8'h0, "MFHI"};
          FN_MTHI:  ascii = {8'h0, "MTHI"};
          FN_MFLO:  ascii = {8'h0, "MFLO"};
          FN_MTLO:  ascii = {8'h0, "MTLO"};
          FN_ADD:   ascii = {16'h0, "ADD"};
          FN_ADDU:  ascii = {8'h0, "ADDU"};
          FN_SUB:   ascii = {16'h0, "SUB"};
          FN_SUBU:  ascii = {8'h0, "SUBU"};
          FN_SLT:   ascii = {16'h0, "SLT"};
          FN_SLTU:  ascii = {8'h0, "SLTU"};
          FN_MULT:  ascii = {8'h0, "MULT"};
          FN_MULTU: ascii = "MULTU";
          FN_DIV:   ascii = {16'h0, "DIV"};
          FN_DIVU:  ascii = {8'h0, "DIVU"};
          FN_JR:    ascii = {24'h0, "JR"};
          FN_JALR:  ascii = {8'h0, "JALR"};
          FN_SYSC:  ascii = {8'h0, "SYSC"};
          FN_BREAK: ascii = {16'h0, "BRE"};
          default:  ;
        endcase
      end
      // Six-letter names keep their last five characters: 40 bits hold only five.
      OP_REGIMM: begin
        case (rt)
          RT_BGEZ:   ascii = {8'h0, "BGEZ"};
          RT_BLTZ:   ascii = {8'h0, "BLTZ"};
          RT_BGEZAL: ascii = "GEZAL";
          RT_BLTZAL: ascii = "LTZAL";
          default:   ;
        endcase
      end
      OP_COP0: begin
        case (rs)
          RS_MTC0: ascii = {8'h0, "MTC0"};
          RS_MFC0: ascii = {8'h0, "MFC0"};
          RS_ERET: ascii = {8'h0, "ERET"};
          default: ;
        endcase
      end
      OP_ANDI:  ascii = {8'h0, "ANDI"};
      OP_XORI:  ascii = {8'h0, "XORI"};
      OP_LUI:   ascii = {16'h0, "LUI"};
      OP_ORI:   ascii = {16'h0, "ORI"};
      OP_ADDI:  ascii = {8'h0, "ADDI"};
      OP_ADDIU: ascii = "ADDIU";
      OP_SLTI:  ascii = {8'h0, "SLTI"};
      OP_SLTIU: ascii = "SLTIU";
      OP_J:     ascii = {32'h0, "J"};
      OP_JAL:   ascii = {16'h0, "JAL"};
      OP_BEQ:   ascii = {16'h0, "BEQ"};
      OP_BNE:   ascii = {16'h0, "BNE"};
      OP_BGTZ:  ascii = {8'h0, "BGTZ"};
      OP_BLEZ:  ascii = {8'h0, "BLEZ"};
      OP_LB:    ascii = {24'h0, "LB"};
      OP_LBU:   ascii = {16'h0, "LBU"};
      OP_LH:    ascii = {24'h0, "LH"};
      OP_LHU:   ascii = {16'h0, "LHU"};
      OP_LW:    ascii = {24'h0, "LW"};
      OP_SB:    ascii = {24'h0, "SB"};
      OP_SH:    ascii = {24'h0, "SH"};
      OP_SW:    ascii = {24'h0, "SW"};
      default:  ;
    endcase
    if (instr == ERET_WORD) ascii = {8'h0, "ERET"};
    if (instr == 32'h0)     ascii = {16'h0, "NOP"};
  end

endmodule

// File: rtl/instr_trace_buf.sv
// Retire trace buffer: S1 register, S2 decode+write; entries readable 2 cycles after retire.
// Read side is valid/ready; write side never stalls (FIFO mode drops, ring mode overwrites).
module instr_trace_buf
  import instr_trace_buf_pkg::*;
#(
  parameter int NCH   = 1,
  parameter int DEPTH = 16,
  parameter int PC_W  = 32,
  parameter int MODE  = 0,
  parameter int POST  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            ret_valid,
  input  logic [NCH*PC_W-1:0]       ret_pc,
  input  logic [NCH*32-1:0]         ret_instr,
  input  logic                      arm,
  input  logic                      trig,
  input  logic                      trig_pc_en,
  input  logic [PC_W-1:0]           trig_pc,
  input  logic                      clear,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [PC_W-1:0]           rd_pc,
  output logic [31:0]               rd_instr,
  output logic [39:0]               rd_ascii,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      frozen,
  output logic [15:0]               drop_cnt,
  output logic [31:0]               ret_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] POST_L = 8'(POST);

  logic [NCH-1:0]        s1_valid;
  logic [NCH*PC_W-1:0]   s1_pc;
  logic [NCH*32-1:0]     s1_instr;
  logic [NCH*40-1:0]     s1_ascii;

  logic [PC_W-1:0]       mem_pc    [DEPTH];
  logic [31:0]           mem_instr [DEPTH];
  logic [39:0]           mem_ascii [DEPTH];

  logic [AW-1:0]         wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic [CW-1:0]         count_nx, cnt, free;
  logic [15:0]           drop_nx;
  logic [16:0]           dsum;
  logic [1:0]            ndrop;
  logic [7:0]            post_cnt, post_nx;
  trace_state_e          state, state_nx;
  logic                  pop;
  logic [NCH-1:0]        we;
  logic [AW-1:0]         waddr [NCH];
  logic [PC_W-1:0]       chpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
      s1_pc    <= '0;
      s1_instr <= '0;
      ret_cnt  <= '0;
    end else begin
      s1_valid <= ret_valid;
      s1_pc    <= ret_pc;
      s1_instr <= ret_instr;
      ret_cnt  <= ret_cnt + 32'($countones(ret_valid));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_dec
    mnem_decode u_dec (
      .instr (s1_instr[k*32 +: 32]),
      .ascii (s1_ascii[k*40 +: 40])
    );
  end

  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign frozen   = (state == ST_FROZEN);
  assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : '0;
  assign rd_instr = rd_valid ? mem_instr[rd_ptr] : '0;
  assign rd_ascii = rd_valid ? mem_ascii[rd_ptr] : '0;

  // Channels are handled oldest first; the pop frees its slot before any write.
  always_comb begin
    state_nx = state;
    post_nx  = post_cnt;
    we       = '0;
    ndrop    = '0;
    chpc     = '0;
    free     = '0;
    for (int k = 0; k < NCH; k++) waddr[k] = '0;
    cnt   = count - CW'(pop);
    rd_nx = rd_ptr + AW'(pop);
    wr_nx = wr_ptr;

    for (int k = 0; k < NCH; k++) begin
      if (s1_valid[k] && state_nx != ST_FROZEN) begin
        chpc = s1_pc[k*PC_W +: PC_W];
        free = CW'(DEPTH) - cnt;
        if (free != '0) begin
          we[k]    = 1'b1;
          waddr[k] = wr_nx;
          wr_nx    = wr_nx + 1'b1;
          cnt      = cnt + 1'b1;
        end else if (MODE == 1) begin
          we[k]    = 1'b1;
          waddr[k] = wr_nx;
          wr_nx    = wr_nx + 1'b1;
          rd_nx    = rd_nx + 1'b1;
          ndrop    = ndrop + 2'd1;
        end else begin
          ndrop = ndrop + 2'd1;
        end

        // The matching entry is not counted against the post-trigger budget.
        if (state_nx == ST_ARMED && trig_pc_en && chpc == trig_pc) begin
          post_nx  = POST_L;
          state_nx = (POST == 0) ? ST_FROZEN : ST_POST;
        end else if (state_nx == ST_POST && we[k]) begin
          post_nx = post_nx - 8'd1;
          if (post_nx == 8'd0) state_nx = ST_FROZEN;
        end
      end
    end

    if (state_nx == ST_ARMED && trig) begin
      post_nx  = POST_L;
      state_nx = (POST == 0) ? ST_FROZEN : ST_POST;
    end
    if (state == ST_IDLE && arm) state_nx = ST_ARMED;

    dsum    = {1'b0, drop_cnt} + {15'd0, ndrop};
    drop_nx = dsum[16] ? 16'hFFFF : dsum[15:0];

    if (clear) begin
      state_nx = ST_IDLE;
      post_nx  = '0;
      we       = '0;
      cnt      = '0;
      wr_nx    = '0;
      rd_nx    = '0;
      drop_nx  = '0;
    end
    count_nx = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      post_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      post_cnt <= post_nx;
      wr_ptr   <= wr_nx;
      rd_ptr   <= rd_nx;
      count    <= count_nx;
      drop_cnt <= drop_nx;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (we[k]) begin
        mem_pc[waddr[k]]    <= s1_pc[k*PC_W +: PC_W];
        mem_instr[waddr[k]] <= s1_instr[k*32 +: 32];
        mem_ascii[waddr[k]] <= s1_ascii[k*40 +: 40];
      end
    end
  end

endmodule

// File: tb/tb_instr_trace_buf.sv
// Directed bench: a FIFO-mode and a ring-mode instance (NCH=2, DEPTH=4, POST=2) on shared stimulus.
module tb_instr_trace_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ret_valid = '0;
  logic [63:0] ret_pc = '0;
  logic [63:0] ret_instr = '0;
  logic        arm = 1'b0, trig = 1'b0, trig_pc_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        clear = 1'b0, rd_ready = 1'b0;

  logic        f_rd_valid, r_rd_valid, f_frozen, r_frozen;
  logic [31:0] f_rd_pc, r_rd_pc, f_rd_instr, r_rd_instr, f_ret, r_ret;
  logic [39:0] f_rd_ascii, r_rd_ascii;
  logic [2:0]  f_count, r_count;
  logic [15:0] f_drop, r_drop;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned exp_ret = 0;
  logic        rec = 1'b0;
  logic [31:0] popped [$];
  logic [39:0] exp_a [4];
  logic [31:0] exp_i [4];

  always #5 clk = ~clk;

  instr_trace_buf #(.NCH(2), .DEPTH(4), .PC_W(32), .MODE(0), .POST(2)) u_fifo (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .arm(arm), .trig(trig), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(f_rd_valid), .rd_pc(f_rd_pc), .rd_instr(f_rd_instr),
    .rd_ascii(f_rd_ascii), .count(f_count), .frozen(f_frozen), .drop_cnt(f_drop), .ret_cnt(f_ret)
  );

  instr_trace_buf #(.NCH(2), .DEPTH(4), .PC_W(32), .MODE(1), .POST(2)) u_ring (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .arm(arm), .trig(trig), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(r_rd_valid), .rd_pc(r_rd_pc), .rd_instr(r_rd_instr),
    .rd_ascii(r_rd_ascii), .count(r_count), .frozen(r_frozen), .drop_cnt(r_drop), .ret_cnt(r_ret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (rec && f_rd_valid && rd_ready) popped.push_back(f_rd_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ret1(input logic [31:0] pc, input logic [31:0] ins);
    ret_valid = 2'b01;
    ret_pc    = {32'h0, pc};
    ret_instr = {32'h0, ins};
    exp_ret++;
    tick();
    ret_valid = 2'b00;
  endtask

  task automatic ret2(input logic [31:0] pc0, input logic [31:0] pc1);
    ret_valid = 2'b11;
    ret_pc    = {pc1, pc0};
    ret_instr = 64'h0;
    exp_ret  += 2;
    tick();
    ret_valid = 2'b00;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    exp_a = '{40'h00_004E_4F50, 40'h00_004C_5549, 40'h00_4552_4554, 40'h00_004E_2D52};
    exp_i = '{32'h0000_0000, 32'h3C01_1234, 32'h4200_0018, 32'hFC00_0000};

    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", f_rd_valid, 0);
    chk("rst_count", f_count, 0);
    chk("rst_drop", f_drop, 0);
    chk("rst_retcnt", f_ret, 0);
    chk("rst_frozen", f_frozen, 0);
    chk("rst_ascii", f_rd_ascii, 0);

    // Decode and 2-cycle visibility
    ret1(32'h0, exp_i[0]);
    chk("lat1_valid", f_rd_valid, 0);
    ret1(32'h4, exp_i[1]);
    chk("lat2_valid", f_rd_valid, 1);
    chk("lat2_ascii", f_rd_ascii, exp_a[0]);
    ret1(32'h8, exp_i[2]);
    ret1(32'hC, exp_i[3]);
    idle(2);
    chk("dec_fcount", f_count, 4);
    chk("dec_rcount", r_count, 4);
    chk("dec_retcnt", f_ret, exp_ret);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dec_ascii", f_rd_ascii, exp_a[i]);
      chk("dec_instr", f_rd_instr, exp_i[i]);
      tick();
    end
    rd_ready = 1'b0;
    chk("empty_valid", f_rd_valid, 0);
    chk("empty_ascii", f_rd_ascii, 0);
    chk("empty_pc", r_rd_pc, 0);

    // Overflow: FIFO drops new, ring overwrites oldest
    for (int i = 0; i < 6; i++) ret1(32'h100 + 32'(4 * i), 32'h3C01_1234);
    idle(2);
    chk("fifo_count", f_count, 4);
    chk("fifo_drop", f_drop, 2);
    chk("fifo_head", f_rd_pc, 32'h100);
    chk("ring_count", r_count, 4);
    chk("ring_drop", r_drop, 2);
    chk("ring_head", r_rd_pc, 32'h108);
    pulse_clear();
    chk("clr_fcount", f_count, 0);
    chk("clr_fdrop", f_drop, 0);
    chk("clr_rdrop", r_drop, 0);
    chk("clr_retcnt", f_ret, exp_ret);

    // One free slot, both channels valid
    ret1(32'h300, 32'h0); ret1(32'h304, 32'h0); ret1(32'h308, 32'h0);
    ret2(32'h30C, 32'h310);
    idle(2);
    chk("dual_fcount", f_count, 4);
    chk("dual_fdrop", f_drop, 1);
    chk("dual_rdrop", r_drop, 1);
    chk("dual_rhead", r_rd_pc, 32'h304);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dual_fpc", f_rd_pc, 32'h300 + 32'(4 * i));
      chk("dual_rpc", r_rd_pc, 32'h304 + 32'(4 * i));
      tick();
    end
    rd_ready = 1'b0;
    pulse_clear();

    // Same with a pop on the cycle the pair is written
    ret1(32'h400, 32'h0); ret1(32'h404, 32'h0); ret1(32'h408, 32'h0);
    ret2(32'h40C, 32'h410);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    idle(1);
    chk("dpop_fcount", f_count, 4);
    chk("dpop_fdrop", f_drop, 0);
    chk("dpop_rdrop", r_drop, 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dpop_fpc", f_rd_pc, 32'h404 + 32'(4 * i));
      tick();
    end
    rd_ready = 1'b0;
    pulse_clear();

    // PC-match trigger with POST=2
    trig_pc_en = 1'b1;
    trig_pc    = 32'h200;
    arm = 1'b1; tick(); arm = 1'b0;
    rd_ready = 1'b1;
    rec = 1'b1;
    for (int i = 0; i < 8; i++) ret1(32'h1F8 + 32'(4 * i), 32'h0);
    idle(3);
    rec = 1'b0;
    rd_ready = 1'b0;
    chk("trg_npop", popped.size(), 5);
    for (int i = 0; i < popped.size() && i < 5; i++)
      chk("trg_pc", popped[i], 32'h1F8 + 32'(4 * i));
    chk("trg_ffrozen", f_frozen, 1);
    chk("trg_rfrozen", r_frozen, 1);
    chk("trg_fcount", f_count, 0);
    chk("trg_fdrop", f_drop, 0);
    chk("trg_retcnt", f_ret, exp_ret);
    ret1(32'h300, 32'h0);
    idle(2);
    chk("frz_fcount", f_count, 0);
    chk("frz_rcount", r_count, 0);
    chk("frz_retcnt", r_ret, exp_ret);

    // clear beats a simultaneous trig and pop
    pulse_clear();
    trig_pc_en = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 5; i++) ret1(32'h500 + 32'(4 * i), 32'h0);
    idle(2);
    chk("pre_fdrop", f_drop, 1);
    clear = 1'b1; trig = 1'b1; rd_ready = 1'b1;
    tick();
    clear = 1'b0; trig = 1'b0; rd_ready = 1'b0;
    chk("cpri_fcount", f_count, 0);
    chk("cpri_rcount", r_count, 0);
    chk("cpri_frozen", f_frozen, 0);
    chk("cpri_fdrop", f_drop, 0);
    chk("cpri_rdrop", r_drop, 0);
    chk("cpri_valid", f_rd_valid, 0);
    for (int i = 0; i < 3; i++) ret1(32'h600 + 32'(4 * i), 32'h0);
    idle(2);
    chk("idle_fcount", f_count, 3);
    chk("idle_frozen", f_frozen, 0);

    // Reset mid-flight discards S1
    pulse_clear();
    ret1(32'h700, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ret = 0;
    idle(2);
    chk("mrst_count", f_count, 0);
    chk("mrst_valid", f_rd_valid, 0);
    chk("mrst_retcnt", f_ret, exp_ret);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_trace_buf.md
Name: instr_trace_buf

Overview:
- Debug trace capture for the MIPS pipeline: takes up to NCH retired instructions per cycle from writeback.
- Registers each instruction, decodes it to a right-aligned ASCII mnemonic and stores {pc, instr, mnemonic} in a DEPTH-entry buffer.
- Buffer is drained by a valid/ready read port to the debug UART/ILA path.
- Adds FIFO/ring modes, trigger-and-freeze capture, and drop/retire counters.

Parameters:
- NCH, 1, retire channels per cycle (1 or 2); ch0 is older than ch1.
- DEPTH, 16, buffer entries (power of 2, 4..256).
- PC_W, 32, PC width.
- MODE, 0, 0 = FIFO (drop new entries when full), 1 = ring (overwrite oldest).
- POST, 4, entries written after trigger before freeze (0..DEPTH-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ret_valid  in  NCH  per-channel retire strobe
- ret_pc  in  NCH*PC_W  retired PCs, ch0 in LSBs
- ret_instr  in  NCH*32  retired instruction words
- arm  in  1  pulse; arms the trigger
- trig  in  1  external trigger pulse
- trig_pc_en  in  1  enable PC-match trigger
- trig_pc  in  PC_W  PC to match
- clear  in  1  pulse; empties buffer, returns to IDLE
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  buffer non-empty
- rd_pc  out  PC_W  head entry PC
- rd_instr  out  32  head entry instruction
- rd_ascii  out  40  head entry mnemonic
- count  out  clog2(DEPTH)+1  occupancy
- frozen  out  1  capture stopped
- drop_cnt  out  16  entries lost; saturates at 0xFFFF
- ret_cnt  out  32  total retires seen; wraps

Behaviour:
- Reset: all outputs 0, pointers 0, state IDLE. Read data outputs are 0 when empty.
- Pipeline:
  - S1 registers ret_*.
  - S2 decodes and writes the buffer.
  - An entry is visible on rd_* 2 cycles after its retire strobe.
  - ret_cnt increments by popcount(ret_valid) at S1, in every state.
- Decode, opcodes per defines2.vh:
  - Output is ASCII, right-aligned in 40 bits, unused high bytes 0x00.
  - instr==0 -> "NOP"; 0x42000018 -> "ERET". These two override everything else.
  - SPECIAL funct: AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV MFHI MTHI MFLO MTLO ADD ADDU SUB SUBU SLT SLTU MULT MULTU DIV DIVU JR JALR map to their names; SYSCALL -> "SYSC"; BREAK -> "BRE".
  - I/J opcodes: ANDI XORI LUI ORI ADDI ADDIU SLTI SLTIU J JAL BEQ BNE BGTZ BLEZ LB LBU LH LHU LW SB SH SW map to their names.
  - REGIMM rt: BGEZ BGEZAL BLTZ BLTZAL map to their names.
  - COP0 rs=00100 -> "MTC0"; rs=00000 -> "MFC0"; rs=10000 -> "ERET".
  - Anything else, including unknown REGIMM/COP0 codes -> "N-R".
- Read: pop when rd_valid && rd_ready. rd_* are taken from the registered head; the next entry appears the cycle after a pop.
- Write, per cycle, S2 valid channels in order ch0, ch1:
  - free = DEPTH - count + pop.
  - FIFO mode: write while free > 0. Each channel that does not fit increments drop_cnt; ch1 drops first.
  - Ring mode: every valid channel is written. When full, the oldest entry is overwritten, the read pointer advances with it, and drop_cnt increments per overwrite. A pop in the same cycle counts as freeing a slot first.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: capturing. arm -> ARMED.
  - ARMED: capturing. trig, or an S2 valid entry with trig_pc_en && pc==trig_pc -> POST, with post_cnt = POST.
    - The matching entry itself is written.
    - If POST==0, go directly to FROZEN after that write.
  - POST: each written entry decrements post_cnt; reaching 0 -> FROZEN.
  - FROZEN: frozen=1. No writes and no drop_cnt increments. Reads still allowed.
  - clear (any state): count=0, pointers=0, drop_cnt=0, state IDLE. ret_cnt is kept. clear has priority over arm, trig, writes and pops in the same cycle.
  - arm while in ARMED, POST or FROZEN is ignored.
- rst mid-operation: state as at reset, and S1 contents are discarded.

Decomposition:
- Shared package/header (defines2.vh): opcode, funct, REGIMM and COP0 rs constants; the ERET word; the trace state encoding (IDLE/ARMED/POST/FROZEN).
- One sub-module, mnem_decode: purely combinational, 32-bit instr -> 40-bit ASCII. Instantiated NCH times at S2.

Test Plan:
- Reset, then retire 0x00000000, 0x3C011234, 0x42000018, 0xFC000000 on ch0 -> rd_ascii reads "NOP", "LUI", "ERET", "N-R" in order; first rd_valid 2 cycles after the first strobe.
- MODE=0, DEPTH=4, rd_ready=0, 6 retires -> count=4, drop_cnt=2, head is the first PC.
- MODE=1, DEPTH=4, 6 retires with PCs 0x100..0x114 -> count=4, head pc=0x108, drop_cnt=2.
- NCH=2, one free slot, both channels valid -> ch0 stored, ch1 dropped. Same case with a simultaneous pop -> both stored.
- arm; trig_pc_en=1, trig_pc=0x200, POST=2; stream 0x1F8..0x214 -> frozen=1, last stored pc=0x208, further retires not stored, ret_cnt still counting.
- clear in the same cycle as trig and a pop -> count=0, state IDLE, frozen=0, drop_cnt=0.
